// File: rtl/dmem_lsu_sram.sv
// Byte-addressed RV32 data memory behind the LSU: synchronous-read SRAM, lane-enabled stores,
// extended sub-word loads, one-entry response slot. Alignment errors enabled by DMEM_MISALIGN_CHECK_EN.
module dmem_lsu_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH_WORDS);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [31:0]       mem_r [0:DEPTH_WORDS-1];
  logic [31:0]       rd_word_r;
  logic              ld_en_r;
  logic [1:0]        ld_size_r;
  logic [1:0]        ld_lane_r;
  logic              ld_uns_r;
  logic              err_r;

  logic              rsp_valid_s;
  logic              req_ready_s;
  logic              accept_s;
  logic [ADDR_W-3:0] word_full_s;
  logic [IDX_W-1:0]  word_idx_s;
  logic              range_err_s;
  logic              size_err_s;
  logic              misalign_s;
  logic              req_err_s;
  logic [1:0]        lane_s;
  logic [3:0]        be_s;
  logic [31:0]       wlanes_s;
  logic              do_write_s;
  logic              do_read_s;

  // Shift the addressed byte/half down to bit 0 and extend it; words pass through.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] ext;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   ext = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ext = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ext = word;
    endcase
    return ext;
  endfunction

  assign word_full_s = i_req_addr[ADDR_W-1:2];
  assign word_idx_s  = word_full_s[IDX_W-1:0];
  assign range_err_s = ({1'b0, word_full_s} >= DEPTH_L);
  assign size_err_s  = (i_req_size == 2'b11);
  assign req_err_s   = range_err_s | size_err_s | misalign_s;
  assign accept_s    = i_req_valid & req_ready_s;
  assign do_write_s  = accept_s & i_req_we & ~req_err_s;
  assign do_read_s   = accept_s & ~i_req_we & ~req_err_s;

  // Alignment policy: flag misaligned half/word, or silently clear the offending low bits.
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign_s = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                 ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    case (i_req_size)
      2'b00:   lane_s = i_req_addr[1:0];
      2'b01:   lane_s = {i_req_addr[1], 1'b0};
      default: lane_s = 2'b00;
    endcase
  end

  // Lane enables and store data replicated onto every lane it may land in.
  always_comb begin
    case (i_req_size)
      2'b00: begin
        be_s     = 4'b0001 << lane_s;
        wlanes_s = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        be_s     = 4'b0011 << lane_s;
        wlanes_s = {2{i_req_wdata[15:0]}};
      end
      2'b10: begin
        be_s     = 4'b1111;
        wlanes_s = i_req_wdata;
      end
      default: begin
        be_s     = 4'b0000;
        wlanes_s = 32'h0000_0000;
      end
    endcase
  end

  // SRAM array: lane-masked write and registered read, contents survive reset.
  always_ff @(posedge i_clk) begin
    if (do_write_s && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wlanes_s[8*b +: 8];
        end
      end
    end
    if (do_read_s) begin
      rd_word_r <= mem_r[word_idx_s];
    end
  end

  // Response slot metadata, captured on every accepted request.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ld_en_r   <= 1'b0;
      ld_size_r <= 2'b00;
      ld_lane_r <= 2'b00;
      ld_uns_r  <= 1'b0;
      err_r     <= 1'b0;
    end else if (accept_s) begin
      ld_en_r   <= do_read_s;
      ld_size_r <= i_req_size;
      ld_lane_r <= lane_s;
      ld_uns_r  <= i_req_unsigned;
      err_r     <= req_err_s;
    end
  end

  // Slot state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Slot next state: a new accept always refills the slot, a bare consume drains it.
  always_comb begin
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else if (i_rsp_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Slot outputs; rdata is zero unless the slot holds a successful load.
  always_comb begin
    rsp_valid_s = (state_r == ST_FULL);
    req_ready_s = ~rsp_valid_s | i_rsp_ready;
    o_rsp_valid = rsp_valid_s;
    o_req_ready = req_ready_s;
    o_rsp_err   = err_r;
    if (ld_en_r) begin
      o_rsp_rdata = extend_load(rd_word_r, ld_size_r, ld_lane_r, ld_uns_r);
    end else begin
      o_rsp_rdata = 32'h0000_0000;
    end
  end

endmodule
